// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, iterative Booth multiplier and,
// when SEQ_ALU_DIV_EN is defined, an iterative signed restoring divider.
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   hi,
    output logic               illegal,
    output logic               div_zero
);

    localparam logic [4:0] OP_OR   = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ITER   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     acc_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               qm1_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic               done_reg;
    logic               illegal_reg;

    // Single-cycle result path, evaluated directly from the unlatched operands.
    logic [SHAMT_W-1:0]   shamt;
    logic [2*WIDTH-1:0]   dbl;
    logic [WIDTH-1:0]     ror_res;
    logic [WIDTH-1:0]     rol_res;
    logic [WIDTH-1:0]     sra_res;
    logic [WIDTH-1:0]     single_res;
    logic                 single_ok;
    logic                 is_mul;

    assign shamt   = b[SHAMT_W-1:0];
    assign dbl     = {a, a};
    assign ror_res = WIDTH'(dbl >> shamt);
    assign rol_res = WIDTH'((dbl << shamt) >> WIDTH);
    assign sra_res = $unsigned($signed(a) >>> shamt);
    assign is_mul  = (op == OP_MUL);

    always_comb begin
        single_res = '0;
        single_ok  = 1'b1;
        case (op)
            OP_OR:   single_res = a | b;
            OP_AND:  single_res = a & b;
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_SHR:  single_res = a >> shamt;
            OP_SHRA: single_res = sra_res;
            OP_SHL:  single_res = a << shamt;
            OP_ROR:  single_res = ror_res;
            OP_ROL:  single_res = rol_res;
            OP_NEG:  single_res = -a;
            OP_NOT:  single_res = ~a;
            default: single_ok  = 1'b0;
        endcase
    end

    // Booth step: upper accumulator is one bit wider so subtracting the most-negative
    // multiplicand cannot overflow.
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] booth_sum;

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        case ({q_reg[0], qm1_reg})
            2'b01:   booth_sum = acc_reg + m_ext;
            2'b10:   booth_sum = acc_reg - m_ext;
            default: booth_sum = acc_reg;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    localparam logic [1:0] MODE_MUL  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_DIVZ = 2'd2;

    logic [1:0]     mode_reg;
    logic           q_neg_reg;
    logic           r_neg_reg;
    logic           div_zero_reg;
    logic           is_div;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    assign is_div    = (op == OP_DIV);
    assign div_shift = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_reg};
    assign div_zero  = div_zero_reg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            q_reg        <= '0;
            qm1_reg      <= 1'b0;
            m_reg        <= '0;
            lo_reg       <= '0;
            hi_reg       <= '0;
            done_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            mode_reg     <= MODE_MUL;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        illegal_reg  <= 1'b0;
                        cnt_reg      <= '0;
`ifdef SEQ_ALU_DIV_EN
                        div_zero_reg <= 1'b0;
`endif
                        if (is_mul) begin
                            acc_reg   <= '0;
                            q_reg     <= a;
                            qm1_reg   <= 1'b0;
                            m_reg     <= b;
`ifdef SEQ_ALU_DIV_EN
                            mode_reg  <= MODE_MUL;
`endif
                            state_reg <= ST_ITER;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (is_div) begin
                            if (b == '0) begin
                                q_reg        <= a;
                                mode_reg     <= MODE_DIVZ;
                                div_zero_reg <= 1'b1;
                                state_reg    <= ST_FINISH;
                            end else begin
                                acc_reg   <= '0;
                                q_reg     <= mag(a);
                                m_reg     <= mag(b);
                                q_neg_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                                r_neg_reg <= a[WIDTH-1];
                                mode_reg  <= MODE_DIV;
                                state_reg <= ST_ITER;
                            end
                        end
`endif
                        else if (single_ok) begin
                            lo_reg   <= single_res;
                            hi_reg   <= '0;
                            done_reg <= 1'b1;
                        end else begin
                            lo_reg      <= '0;
                            hi_reg      <= '0;
                            illegal_reg <= 1'b1;
                            done_reg    <= 1'b1;
                        end
                    end
                end
                ST_ITER: begin
`ifdef SEQ_ALU_DIV_EN
                    if (mode_reg == MODE_DIV) begin
                        if (!div_diff[WIDTH]) begin
                            acc_reg <= div_diff;
                            q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_reg <= div_shift;
                            q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        acc_reg <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q_reg   <= {booth_sum[0], q_reg[WIDTH-1:1]};
                        qm1_reg <= q_reg[0];
                    end
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1))
                        state_reg <= ST_FINISH;
                end
                ST_FINISH: begin
`ifdef SEQ_ALU_DIV_EN
                    case (mode_reg)
                        MODE_DIVZ: begin
                            lo_reg <= '1;
                            hi_reg <= q_reg;
                        end
                        MODE_DIV: begin
                            lo_reg <= q_neg_reg ? -q_reg : q_reg;
                            hi_reg <= r_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                        end
                        default: begin
                            lo_reg <= q_reg;
                            hi_reg <= acc_reg[WIDTH-1:0];
                        end
                    endcase
`else
                    lo_reg <= q_reg;
                    hi_reg <= acc_reg[WIDTH-1:0];
`endif
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign lo      = lo_reg;
    assign hi      = hi_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 plus a WIDTH=8 instance for narrow-build checks.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, illegal, div_zero;
    logic [31:0] lo, hi;

    logic        start8 = 1'b0;
    logic [4:0]  op8 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, illegal8, div_zero8;
    logic [7:0]  lo8, hi8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .lo(lo), .hi(hi),
        .illegal(illegal), .div_zero(div_zero)
    );

    seq_alu #(.WIDTH(8), .SHAMT_W(3)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .lo(lo8), .hi(hi8),
        .illegal(illegal8), .div_zero(div_zero8)
    );

    // Issues one op from just after an edge; lat is the edge count to done, -1 on timeout.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
        op = o; a = x; b = y; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        int extra;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, illegal, div_zero, lo, hi} !== 68'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b ill=%b dz=%b lo=%h hi=%h, want all 0",
                     busy, done, illegal, div_zero, lo, hi);
        end
        clr = 1'b1;
        run_op(5'd10, 32'h0F0F_0F0F, 32'h0, lat);
        op = 5'd11; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_mul_busy: got busy=%b want 1", busy);
        end
        clr = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, illegal, div_zero, lo, hi} !== 68'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: got busy=%b done=%b ill=%b lo=%h hi=%h, want all 0",
                     busy, done, illegal, lo, hi);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d busy/done cycles want 0", extra);
        end
        run_op(5'd2, 32'd5, 32'd7, lat);
        tests_run++;
        if (lat !== 1 || lo !== 32'd12 || hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_add: got lat=%0d lo=%h hi=%h want lat=1 lo=0000000c hi=0", lat, lo, hi);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_stream();
        logic [4:0]  ops [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd8};
        logic [31:0] exp [6] = '{32'hF000_000F, 32'h0000_0004, 32'hF000_0013,
                                 32'hF000_000B, 32'hFF00_0000, 32'h0000_00FF};
        a = 32'hF000_000F; b = 32'h0000_0004;
        op = ops[0]; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b1 || lo !== exp[i] || hi !== 32'd0) begin
                tests_failed++;
                $display("FAIL stream_%0d: got done=%b lo=%h hi=%h want done=1 lo=%h hi=0",
                         i, done, lo, hi, exp[i]);
            end
            if (i < 5) op = ops[i+1];
            else start = 1'b0;
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_end: got done=%b want 0", done);
        end
        $display("[TB] test_stream done");
    endtask

    task automatic test_single_misc();
        logic [4:0]  ops [7] = '{5'd9, 5'd10, 5'd6, 5'd4, 5'd7, 5'd3, 5'd2};
        logic [31:0] av  [7] = '{32'd5, 32'h0F0F_0F0F, 32'h0000_1234, 32'h8000_0000,
                                 32'h0000_0001, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] bv  [7] = '{32'h0, 32'h0, 32'h0000_0020, 32'd31, 32'd1, 32'd1, 32'd1};
        logic [31:0] ev  [7] = '{32'hFFFF_FFFB, 32'hF0F0_F0F0, 32'h0000_1234, 32'h0000_0001,
                                 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], av[i], bv[i], lat);
            tests_run++;
            if (lat !== 1 || lo !== ev[i] || hi !== 32'd0 || illegal !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_op%0d: got lat=%0d lo=%h hi=%h ill=%b want lat=1 lo=%h hi=0 ill=0",
                         ops[i], lat, lo, hi, illegal, ev[i]);
            end
        end
        $display("[TB] test_single_misc done");
    endtask

    task automatic test_mul();
        int lat;
        int busy_cnt;
        logic [31:0] lo_hold;
        op = 5'd11; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
        lat = -1; busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin op = 5'd2; a = 32'd1; b = 32'd1; end
            if (k == 5) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        tests_run++;
        if (lat !== 34 || busy_cnt !== 33) begin
            tests_failed++;
            $display("FAIL mul_timing: got lat=%0d busy_cycles=%0d want lat=34 busy_cycles=33", lat, busy_cnt);
        end
        tests_run++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            tests_failed++;
            $display("FAIL mul_neg3x7: got hi=%h lo=%h want hi=ffffffff lo=ffffffeb", hi, lo);
        end
        lo_hold = lo;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== lo_hold) begin
            tests_failed++;
            $display("FAIL mul_not_queued: got done=%b busy=%b lo=%h want done=0 busy=0 lo=%h",
                     done, busy, lo, lo_hold);
        end
        run_op(5'd11, 32'h7FFF_FFFF, 32'h8000_0000, lat);
        tests_run++;
        if (lat !== 34 || hi !== 32'hC000_0000 || lo !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL mul_extreme: got lat=%0d hi=%h lo=%h want lat=34 hi=c0000000 lo=80000000",
                     lat, hi, lo);
        end
        run_op(5'd2, 32'd1, 32'd2, lat);
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd3) begin
            tests_failed++;
            $display("FAIL add_after_mul: got hi=%h lo=%h want hi=0 lo=3", hi, lo);
        end
        $display("[TB] test_mul done");
    endtask

`ifdef SEQ_ALU_DIV_EN
    task automatic test_div();
        int lat;
        run_op(5'd12, -32'sd17, 32'd5, lat);
        tests_run++;
        if (lat !== 34 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFE || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_m17_5: got lat=%0d lo=%h hi=%h dz=%b want lat=34 lo=fffffffd hi=fffffffe dz=0",
                     lat, lo, hi, div_zero);
        end
        run_op(5'd12, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        tests_run++;
        if (lo !== 32'h8000_0000 || hi !== 32'd0 || div_zero !== 1'b0 || illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_minneg: got lo=%h hi=%h dz=%b ill=%b want lo=80000000 hi=0 dz=0 ill=0",
                     lo, hi, div_zero, illegal);
        end
        run_op(5'd12, 32'd9, 32'd0, lat);
        tests_run++;
        if (lat !== 2 || lo !== 32'hFFFF_FFFF || hi !== 32'd9 || div_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_zero: got lat=%0d lo=%h hi=%h dz=%b want lat=2 lo=ffffffff hi=9 dz=1",
                     lat, lo, hi, div_zero);
        end
        run_op(5'd12, 32'd7, 32'd2, lat);
        tests_run++;
        if (lo !== 32'd3 || hi !== 32'd1 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_7_2: got lo=%h hi=%h dz=%b want lo=3 hi=1 dz=0", lo, hi, div_zero);
        end
        $display("[TB] test_div done");
    endtask
`else
    task automatic test_div_off();
        int lat;
        run_op(5'd12, 32'd9, 32'd3, lat);
        tests_run++;
        if (lat !== 1 || illegal !== 1'b1 || lo !== 32'd0 || hi !== 32'd0 || div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL div_off: got lat=%0d ill=%b lo=%h hi=%h dz=%b want lat=1 ill=1 lo=0 hi=0 dz=0",
                     lat, illegal, lo, hi, div_zero);
        end
        $display("[TB] test_div_off done");
    endtask
`endif

    task automatic test_illegal();
        int lat;
        run_op(5'd20, 32'h1234_5678, 32'h1, lat);
        tests_run++;
        if (lat !== 1 || illegal !== 1'b1 || lo !== 32'd0 || hi !== 32'd0) begin
            tests_failed++;
            $display("FAIL illegal_op20: got lat=%0d ill=%b lo=%h hi=%h want lat=1 ill=1 lo=0 hi=0",
                     lat, illegal, lo, hi);
        end
        run_op(5'd2, 32'd1, 32'd2, lat);
        tests_run++;
        if (illegal !== 1'b0 || lo !== 32'd3) begin
            tests_failed++;
            $display("FAIL illegal_clear: got ill=%b lo=%h want ill=0 lo=3", illegal, lo);
        end
        $display("[TB] test_illegal done");
    endtask

    task automatic test_width8();
        int lat;
        op8 = 5'd11; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin lat = k; break; end
        end
        tests_run++;
        if (lat !== 10 || {hi8, lo8} !== 16'h4000) begin
            tests_failed++;
            $display("FAIL w8_mul: got lat=%0d hilo=%h want lat=10 hilo=4000", lat, {hi8, lo8});
        end
        op8 = 5'd7; a8 = 8'h81; b8 = 8'h01; start8 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin lat = k; break; end
        end
        tests_run++;
        if (lat !== 1 || lo8 !== 8'hC0 || hi8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL w8_ror: got lat=%0d lo=%h hi=%h want lat=1 lo=c0 hi=00", lat, lo8, hi8);
        end
        $display("[TB] test_width8 done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single_misc();
        test_mul();
`ifdef SEQ_ALU_DIV_EN
        test_div();
`else
        test_div_off();
`endif
        test_illegal();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath's combinational ALU.
- Adds a start/done handshake, more logic/shift/arithmetic ops, and an iterative signed multiplier plus an optional iterative divider.
- Results land in 2*WIDTH HI/LO result registers.
- Sits between the register-file read ports and the Z/HI/LO writeback path; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width in bits (≥4, even).
- SHAMT_W, 5, shift-amount bits taken from B[SHAMT_W-1:0]; must equal clog2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  5  operation code, latched on acceptance.
- a  in  WIDTH  operand A, latched on acceptance.
- b  in  WIDTH  operand B, latched on acceptance.
- busy  out  1  high while a multi-cycle op iterates.
- done  out  1  one-cycle pulse: result registers updated.
- lo  out  WIDTH  primary result / MUL low word / DIV quotient.
- hi  out  WIDTH  MUL high word / DIV remainder; 0 for single-cycle ops.
- illegal  out  1  sticky-until-next-accept: unsupported op.
- div_zero  out  1  sticky-until-next-accept: DIV with b=0.

Behaviour:
- Reset (clr=0, async): state IDLE; busy=0, done=0, lo=0, hi=0, illegal=0, div_zero=0; iteration counter=0.
- Opcodes:
  - 0 OR, 1 AND, 2 ADD (codes 0-2 keep the existing encoding).
  - 3 SUB, 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 ROL.
  - 9 NEG (0-a), 10 NOT (~a), 11 MUL, 12 DIV.
  - All other codes are illegal.
- Arithmetic: ADD/SUB/NEG wrap modulo 2^WIDTH; no carry or flags are output. Shifts and rotates use b[SHAMT_W-1:0] only; an amount of 0 returns a unchanged.
- Acceptance: on a rising edge with state IDLE and start=1. start while busy=1 is ignored and not queued. On acceptance, illegal and div_zero are cleared and then re-evaluated for the new op.
- States:
  - IDLE: on accept of a single-cycle or illegal op, write the result that edge and assert done next cycle; stay IDLE. On accept of MUL/DIV, go to ITER with counter=0 and busy=1.
  - ITER: one radix-2 step per edge; counter increments. After WIDTH steps, go to FINISH.
  - FINISH: commit hi/lo, pulse done, busy=0, return to IDLE. start is accepted again on the next edge.
- Latency, counted in edges from acceptance to done high:
  - single-cycle ops: 1.
  - MUL/DIV: WIDTH+2, i.e. 34 at WIDTH=32.
- Back-to-back single-cycle ops: start may stay high and one op is accepted per cycle, giving one done per cycle.
- MUL: signed × signed using radix-2 Booth, full 2*WIDTH product. {hi,lo}=a*b.
- DIV: signed restoring division on magnitudes with sign fix-up at FINISH.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ -1: lo=most-negative, hi=0, no flag.
- Divide by zero, detected at accept: skip ITER and go straight to FINISH next edge (latency 2). lo=all ones, hi=a, div_zero=1.
- Illegal op: lo=0, hi=0, illegal=1, done pulses with latency 1.
- lo/hi hold their value between done pulses and are not disturbed while iterating. Internal accumulators are separate from lo/hi.
- clr asserted mid-ITER: immediate return to reset values; the partial result is discarded and no done pulse follows.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: DIV (op 12) is implemented as above, including div_zero.
- Undefined: the divider datapath is not built. Op 12 is treated as illegal (illegal=1, lo=hi=0, latency 1). div_zero is tied to 0.

Test Plan:
- Reset: hold clr=0 mid-MUL at iteration 10, then release → all outputs 0, no done pulse. Next accept of ADD 5+7 gives done after 1 edge with lo=12, hi=0.
- Single-cycle stream: start held high for OR, AND, ADD, SUB, SHRA, ROL on a=0xF000_000F, b=0x0000_0004 → six consecutive done pulses with lo = 0xF000_000F, 0x4, 0xF000_0013, 0xF000_000B, 0xFF00_0000, 0x0000_00FF.
- MUL signed: a=-3 (0xFFFF_FFFD), b=7 → busy high for 33 cycles, done at edge 34, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. A start during busy is ignored.
- DIV (SEQ_ALU_DIV_EN): a=-17, b=5 → lo=-3 (0xFFFF_FFFD), hi=-2 (0xFFFF_FFFE). Then a=9, b=0 → done at edge 2, lo=0xFFFF_FFFF, hi=9, div_zero=1.
- Illegal and macro-off: op=20 → illegal=1, lo=0. Build without SEQ_ALU_DIV_EN and issue op=12 → illegal=1, done latency 1. A following legal op clears illegal.
- WIDTH=8 build: MUL a=0x80, b=0x80 → {hi,lo}=0x4000, done at edge 10. ROR a=0x81, b=1 → lo=0xC0.
